// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    RSP  = 3'b100
  } state_t;

  localparam logic OWN_I   = 1'b0;
  localparam logic OWN_D   = 1'b1;

  localparam logic KIND_RD = 1'b0;
  localparam logic KIND_WR = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Two-requester grant logic: fixed data-over-fetch priority, or round-robin
// when MEM_ARB_RR_EN is defined (ptr names the side that wins a tie).
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic ptr,
`endif
  output logic i_gnt,
  output logic d_gnt
);

  always_comb begin
    d_gnt = d_req;
    i_gnt = i_req & ~d_req;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req && ptr == OWN_I) begin
      i_gnt = 1'b1;
      d_gnt = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the fetch and load/store channels, one
// transaction in flight. MEM_ARB_RR_EN selects round-robin arbitration.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  input  logic                i_rready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_wen,
  input  logic                d_ren,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_strb,
  output logic                d_req_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  input  logic                d_rready,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_wen,
  output logic                m_ren,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_strb,
  input  logic                m_req_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic                busy
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] strb_q;
  logic                kind_q;
  logic                owner_q;
  logic                i_gnt, d_gnt, accept;

`ifdef MEM_ARB_RR_EN
  logic ptr_q;

  always_ff @(posedge clk) begin
    if (rst)         ptr_q <= OWN_D;
    else if (accept) ptr_q <= d_gnt ? OWN_I : OWN_D;
  end
`endif

  mem_arb_grant u_grant (
    .i_req (i_req_valid),
    .d_req (d_wen | d_ren),
`ifdef MEM_ARB_RR_EN
    .ptr   (ptr_q),
`endif
    .i_gnt (i_gnt),
    .d_gnt (d_gnt)
  );

  // Readies are masked during reset so nothing is handshaken on a cycle
  // whose state update the reset will discard.
  assign i_req_ready = (state_q == IDLE) & ~rst & i_gnt;
  assign d_req_ready = (state_q == IDLE) & ~rst & d_gnt;
  assign accept      = i_req_ready | d_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      kind_q  <= KIND_RD;
      owner_q <= OWN_I;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= d_gnt ? d_addr : i_addr;
        wdata_q <= d_gnt ? d_wdata : '0;
        strb_q  <= d_gnt ? d_strb : '0;
        kind_q  <= (d_gnt && d_wen) ? KIND_WR : KIND_RD;
        owner_q <= d_gnt ? OWN_D : OWN_I;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    m_wen    = 1'b0;
    m_ren    = 1'b0;
    m_rready = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        m_wen = (kind_q == KIND_WR);
        m_ren = (kind_q == KIND_RD);
        if (m_req_ready) state_d = (kind_q == KIND_WR) ? IDLE : RSP;
      end
      RSP: begin
        m_rready = (owner_q == OWN_D) ? d_rready : i_rready;
        i_rvalid = (owner_q == OWN_I) & m_rvalid;
        d_rvalid = (owner_q == OWN_D) & m_rvalid;
        if (m_rvalid && m_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_strb  = strb_q;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter (one vector per cycle).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        i_req_valid, i_rready, d_wen, d_ren, d_rready;
  logic [3:0]  d_strb;
  logic        m_req_ready, m_rvalid;
  logic        i_req_ready, i_rvalid, d_req_ready, d_rvalid;
  logic        m_wen, m_ren, m_rready, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_strb;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_addr(d_addr), .d_wen(d_wen), .d_ren(d_ren), .d_wdata(d_wdata),
    .d_strb(d_strb), .d_req_ready(d_req_ready), .d_rdata(d_rdata),
    .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_addr(m_addr), .m_wen(m_wen), .m_ren(m_ren), .m_wdata(m_wdata),
    .m_strb(m_strb), .m_req_ready(m_req_ready), .m_rdata(m_rdata),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .busy(busy)
  );

  // ctl = {rst, ireq, dwen, dren, mrr, mrv, irr, drr}
  // fl  = {i_req_ready, d_req_ready, i_rvalid, d_rvalid, m_wen, m_ren, m_rready, busy}
  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [3:0]  dstrb;
    logic [7:0]  fl;
    logic [31:0] maddr, mwdata, rdata;
    logic [3:0]  mstrb;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] cur_iaddr, cur_daddr, cur_dwdata, cur_mrdata;
  logic [3:0]  cur_dstrb;

  task automatic add(input string n, input logic [7:0] ctl, input logic [7:0] fl,
                     input logic [31:0] ma, input logic [31:0] mw,
                     input logic [3:0] ms, input logic [31:0] rd);
    vec_t v;
    v.name = n; v.ctl = ctl; v.fl = fl;
    v.iaddr = cur_iaddr; v.daddr = cur_daddr; v.dwdata = cur_dwdata;
    v.dstrb = cur_dstrb; v.mrdata = cur_mrdata;
    v.maddr = ma; v.mwdata = mw; v.mstrb = ms; v.rdata = rd;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    {rst, i_req_valid, d_wen, d_ren, m_req_ready, m_rvalid, i_rready, d_rready} = v.ctl;
    i_addr = v.iaddr; d_addr = v.daddr; d_wdata = v.dwdata;
    d_strb = v.dstrb; m_rdata = v.mrdata;
  endtask

  task automatic check(input vec_t v);
    logic [7:0]  fl;
    logic [31:0] rd;
    fl = {i_req_ready, d_req_ready, i_rvalid, d_rvalid, m_wen, m_ren, m_rready, busy};
    rd = i_rvalid ? i_rdata : (d_rvalid ? d_rdata : 32'h0);
    checks++;
    if (fl !== v.fl || m_addr !== v.maddr || m_wdata !== v.mwdata ||
        m_strb !== v.mstrb || rd !== v.rdata) begin
      fails++;
      $display("FAIL %s: got fl=%b addr=%h wdata=%h strb=%h rdata=%h, want fl=%b addr=%h wdata=%h strb=%h rdata=%h",
               v.name, fl, m_addr, m_wdata, m_strb, rd,
               v.fl, v.maddr, v.mwdata, v.mstrb, v.rdata);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    {rst, i_req_valid, d_wen, d_ren, m_req_ready, m_rvalid, i_rready, d_rready} = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_strb = '0; m_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    cur_iaddr = 0; cur_daddr = 0; cur_dwdata = 0; cur_dstrb = 0; cur_mrdata = 0;
    add("reset",      8'b1_0_0_0_0_0_0_0, 8'b0000_0000, 32'h0, 32'h0, 4'h0, 32'h0);

    // tie right after reset: data first, then the waiting fetch
    cur_iaddr = 32'h104; cur_daddr = 32'h300; cur_mrdata = 32'h1111_2222;
    add("tie_acc_d",  8'b0_1_0_1_1_0_1_1, 8'b0100_0000, 32'h0,   32'h0, 4'h0, 32'h0);
    add("tie_req_d",  8'b0_1_0_0_1_0_1_1, 8'b0000_0101, 32'h300, 32'h0, 4'h0, 32'h0);
    add("tie_rsp_d",  8'b0_1_0_0_1_1_1_1, 8'b0001_0011, 32'h300, 32'h0, 4'h0, 32'h1111_2222);
    add("tie_acc_i",  8'b0_1_0_0_1_0_1_1, 8'b1000_0000, 32'h300, 32'h0, 4'h0, 32'h0);
    add("tie_req_i",  8'b0_0_0_0_1_0_1_1, 8'b0000_0101, 32'h104, 32'h0, 4'h0, 32'h0);
    cur_mrdata = 32'h2402_0005;
    add("tie_rsp_i",  8'b0_0_0_0_1_1_1_1, 8'b0010_0011, 32'h104, 32'h0, 4'h0, 32'h2402_0005);

    // fetch only, zero-wait memory
    cur_iaddr = 32'h100;
    add("f_acc",      8'b0_1_0_0_1_0_1_1, 8'b1000_0000, 32'h104, 32'h0, 4'h0, 32'h0);
    add("f_req",      8'b0_0_0_0_1_0_1_1, 8'b0000_0101, 32'h100, 32'h0, 4'h0, 32'h0);
    add("f_rsp",      8'b0_0_0_0_1_1_1_1, 8'b0010_0011, 32'h100, 32'h0, 4'h0, 32'h2402_0005);
    add("f_idle",     8'b0_0_0_0_0_0_0_0, 8'b0000_0000, 32'h100, 32'h0, 4'h0, 32'h0);

    // store with m_req_ready low for 3 cycles
    cur_daddr = 32'h200; cur_dwdata = 32'hDEAD_BEEF; cur_dstrb = 4'h3;
    add("s_acc",      8'b0_0_1_0_0_0_0_0, 8'b0100_0000, 32'h100, 32'h0, 4'h0, 32'h0);
    add("s_hold1",    8'b0_0_0_0_0_0_0_0, 8'b0000_1001, 32'h200, 32'hDEAD_BEEF, 4'h3, 32'h0);
    add("s_hold2",    8'b0_0_0_0_0_0_0_0, 8'b0000_1001, 32'h200, 32'hDEAD_BEEF, 4'h3, 32'h0);
    add("s_hold3",    8'b0_0_0_0_0_0_0_0, 8'b0000_1001, 32'h200, 32'hDEAD_BEEF, 4'h3, 32'h0);
    add("s_go",       8'b0_0_0_0_1_0_0_0, 8'b0000_1001, 32'h200, 32'hDEAD_BEEF, 4'h3, 32'h0);
    add("s_idle",     8'b0_0_0_0_0_1_1_1, 8'b0000_0000, 32'h200, 32'hDEAD_BEEF, 4'h3, 32'h0);

    // d_wen and d_ren together: write only, no RSP
    cur_daddr = 32'h400; cur_dwdata = 32'h1234_5678; cur_dstrb = 4'hF;
    add("wr_acc",     8'b0_0_1_1_1_0_1_1, 8'b0100_0000, 32'h200, 32'hDEAD_BEEF, 4'h3, 32'h0);
    add("wr_req",     8'b0_0_0_0_1_0_1_1, 8'b0000_1001, 32'h400, 32'h1234_5678, 4'hF, 32'h0);
    add("wr_idle",    8'b0_0_0_0_1_1_1_1, 8'b0000_0000, 32'h400, 32'h1234_5678, 4'hF, 32'h0);

    // response backpressure: i_rready low 4 cycles with m_rvalid high
    cur_iaddr = 32'h500; cur_mrdata = 32'hCAFE_F00D;
    add("bp_acc",     8'b0_1_0_0_1_0_0_1, 8'b1000_0000, 32'h400, 32'h1234_5678, 4'hF, 32'h0);
    add("bp_req",     8'b0_0_0_0_1_0_0_1, 8'b0000_0101, 32'h500, 32'h0, 4'h0, 32'h0);
    add("bp_wait1",   8'b0_0_0_0_1_1_0_1, 8'b0010_0001, 32'h500, 32'h0, 4'h0, 32'hCAFE_F00D);
    add("bp_wait2",   8'b0_0_0_0_1_1_0_1, 8'b0010_0001, 32'h500, 32'h0, 4'h0, 32'hCAFE_F00D);
    add("bp_wait3",   8'b0_0_0_0_1_1_0_1, 8'b0010_0001, 32'h500, 32'h0, 4'h0, 32'hCAFE_F00D);
    add("bp_wait4",   8'b0_0_0_0_1_1_0_1, 8'b0010_0001, 32'h500, 32'h0, 4'h0, 32'hCAFE_F00D);
    add("bp_done",    8'b0_0_0_0_1_1_1_1, 8'b0010_0011, 32'h500, 32'h0, 4'h0, 32'hCAFE_F00D);
    add("bp_idle",    8'b0_0_0_0_0_0_0_0, 8'b0000_0000, 32'h500, 32'h0, 4'h0, 32'h0);

    // reset in REQ during a read aborts; later m_rvalid ignored
    cur_iaddr = 32'h600;
    add("rst_acc",    8'b0_1_0_0_0_0_0_0, 8'b1000_0000, 32'h500, 32'h0, 4'h0, 32'h0);
    add("rst_inreq",  8'b1_0_0_0_0_0_0_0, 8'b0000_0101, 32'h600, 32'h0, 4'h0, 32'h0);
    add("rst_after",  8'b0_0_0_0_1_1_1_1, 8'b0000_0000, 32'h0,   32'h0, 4'h0, 32'h0);
    add("rst_stray",  8'b0_0_0_0_1_1_1_1, 8'b0000_0000, 32'h0,   32'h0, 4'h0, 32'h0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k]);
      #2;
      check(vecs[k]);
    end

    // second tie after a data grant: the build's arbitration mode decides
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    idle_inputs();
    i_req_valid = 1'b1; d_ren = 1'b1; d_addr = 32'h700; i_addr = 32'h708;
    m_req_ready = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
    #2;
    chk1("rr_first_d_rdy", d_req_ready, 1'b1);
    chk1("rr_first_i_rdy", i_req_ready, 1'b0);
    @(negedge clk);
    d_ren = 1'b0;
    @(negedge clk);
    m_rvalid = 1'b1;
    #2;
    chk1("rr_first_d_rvalid", d_rvalid, 1'b1);
    @(negedge clk);
    m_rvalid = 1'b0; d_ren = 1'b1;
    #2;
`ifdef MEM_ARB_RR_EN
    chk1("rr_second_i_rdy", i_req_ready, 1'b1);
    chk1("rr_second_d_rdy", d_req_ready, 1'b0);
`else
    chk1("fix_second_i_rdy", i_req_ready, 1'b0);
    chk1("fix_second_d_rdy", d_req_ready, 1'b1);
`endif
    @(negedge clk);
    i_req_valid = 1'b0; d_ren = 1'b0; m_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk1("rr_end_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
